// File: rtl/seq_detector_ctrl_if.sv
// Word-in / result-out handshake bundle between the packet-side logic and the
// sequence detector controller.
interface seq_detector_ctrl_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic [WORD_W-1:0] word_i;
  logic              word_valid_i;
  logic              word_ready_o;
  logic [CNT_W-1:0]  result_o;
  logic              result_sat_o;
  logic              result_valid_o;
  logic              result_ready_i;

  // Controller side.
  modport slave (
    input  word_i, word_valid_i, result_ready_i,
    output word_ready_o, result_o, result_sat_o, result_valid_o
  );

  // Packet-side producer / result consumer.
  modport master (
    output word_i, word_valid_i, result_ready_i,
    input  word_ready_o, result_o, result_sat_o, result_valid_o
  );
endinterface

// File: rtl/seq_detector_ctrl.sv
// Serialises words MSB-first onto a Mealy sequence detector, counts its hits
// per word and returns the count through a one-deep result slot.
module seq_detector_ctrl #(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned CNT_W    = 4,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic               clock_i,
  input  logic               areset_i,
  seq_detector_ctrl_if.slave ctrl_if,
  output logic               det_bit_o,
  input  logic               det_hit_i,
  output logic               busy_o
);

  localparam int unsigned      BitW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BitW-1:0]  LastIdx = BitW'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StShift, StStall} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              result_sat_q, result_sat_d;
  logic              result_valid_q, result_valid_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              pend_sat_q, pend_sat_d;

  logic [CNT_W-1:0]  hit_fin;
  logic              sat_fin;
  logic              last;
  logic              slot_ok;

  assign last    = (bit_cnt_q == LastIdx);
  // Slot can take a new result if empty or being drained this cycle.
  assign slot_ok = !result_valid_q || ctrl_if.result_ready_i;

  assign busy_o                 = (state_q != StIdle);
  assign ctrl_if.result_o       = result_q;
  assign ctrl_if.result_sat_o   = result_sat_q;
  assign ctrl_if.result_valid_o = result_valid_q;

  // Running count including this cycle's hit, saturating with a sticky flag.
  always_comb begin
    hit_fin = hit_cnt_q;
    sat_fin = sat_q;
    if (det_hit_i) begin
      if (hit_cnt_q == CntMax) begin
        sat_fin = 1'b1;
      end else begin
        hit_fin = hit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state, datapath and handshake outputs.
  always_comb begin
    state_d              = state_q;
    shreg_d              = shreg_q;
    bit_cnt_d            = bit_cnt_q;
    hit_cnt_d            = hit_cnt_q;
    sat_d                = sat_q;
    result_d             = result_q;
    result_sat_d         = result_sat_q;
    result_valid_d       = result_valid_q && !ctrl_if.result_ready_i;
    pend_d               = pend_q;
    pend_sat_d           = pend_sat_q;
    ctrl_if.word_ready_o = 1'b0;
    det_bit_o            = IDLE_BIT;

    unique case (state_q)
      StIdle: begin
        ctrl_if.word_ready_o = 1'b1;
        if (ctrl_if.word_valid_i) begin
          shreg_d   = ctrl_if.word_i;
          bit_cnt_d = '0;
          hit_cnt_d = '0;
          sat_d     = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        det_bit_o = shreg_q[WORD_W-1];
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + BitW'(1);
        hit_cnt_d = hit_fin;
        sat_d     = sat_fin;
        if (last) begin
          bit_cnt_d = '0;
          if (slot_ok) begin
            ctrl_if.word_ready_o = 1'b1;
            result_d       = hit_fin;
            result_sat_d   = sat_fin;
            result_valid_d = 1'b1;
            if (ctrl_if.word_valid_i) begin
              // Gapless reload keeps the detector stream continuous.
              shreg_d   = ctrl_if.word_i;
              hit_cnt_d = '0;
              sat_d     = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            pend_d     = hit_fin;
            pend_sat_d = sat_fin;
            state_d    = StStall;
          end
        end
      end
      StStall: begin
        if (ctrl_if.result_ready_i) begin
          result_d       = pend_q;
          result_sat_d   = pend_sat_q;
          result_valid_d = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock_i or posedge areset_i) begin
    if (areset_i) begin
      state_q        <= StIdle;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      hit_cnt_q      <= '0;
      sat_q          <= 1'b0;
      result_q       <= '0;
      result_sat_q   <= 1'b0;
      result_valid_q <= 1'b0;
      pend_q         <= '0;
      pend_sat_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      hit_cnt_q      <= hit_cnt_d;
      sat_q          <= sat_d;
      result_q       <= result_d;
      result_sat_q   <= result_sat_d;
      result_valid_q <= result_valid_d;
      pend_q         <= pend_d;
      pend_sat_q     <= pend_sat_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_ctrl.sv
// Scoreboard bench: a timing-level model predicts the serial stream, ready,
// busy and per-word counts; a separate monitor checks results on handshake.
module tb_seq_detector_ctrl;
  localparam int unsigned WW     = 8;
  localparam int unsigned CW     = 2;
  localparam logic        IB     = 1'b0;
  localparam int          CntMax = (1 << CW) - 1;

  logic clock_i = 1'b0;
  logic areset_i;
  logic det_bit_o;
  logic det_hit_i;
  logic busy_o;

  seq_detector_ctrl_if #(.WORD_W(WW), .CNT_W(CW)) ifc ();

  seq_detector_ctrl #(.WORD_W(WW), .CNT_W(CW), .IDLE_BIT(IB)) dut (
    .clock_i  (clock_i),
    .areset_i (areset_i),
    .ctrl_if  (ifc),
    .det_bit_o(det_bit_o),
    .det_hit_i(det_hit_i),
    .busy_o   (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {logic b; logic last;} slot_bit_t;
  typedef struct {int cnt; logic sat;} res_t;

  slot_bit_t bits_q[$];
  res_t      exp_q[$];
  int        m_cnt;
  logic      m_sat;
  logic      m_slot_full;
  logic      m_stalled;
  res_t      m_pend;

  // Reference model: evaluated mid-cycle, then advanced as if the edge occurred.
  always @(negedge clock_i) begin : model
    slot_bit_t e;
    res_t      r;
    logic      in_bit, slot_ok, exp_ready, nfull;
    if (areset_i) begin
      chk("rst_valid", ifc.result_valid_o, 0);
      chk("rst_ready", ifc.word_ready_o, 1);
      chk("rst_det_bit", det_bit_o, IB);
      chk("rst_busy", busy_o, 0);
      chk("rst_result", ifc.result_o, 0);
      bits_q.delete();
      exp_q.delete();
      m_cnt = 0; m_sat = 1'b0; m_slot_full = 1'b0; m_stalled = 1'b0;
    end else begin
      in_bit    = bits_q.size() > 0;
      slot_ok   = !m_slot_full || ifc.result_ready_i;
      exp_ready = (!in_bit && !m_stalled) || (in_bit && bits_q[0].last && slot_ok);
      chk("word_ready", ifc.word_ready_o, exp_ready);
      chk("busy", busy_o, in_bit || m_stalled);
      chk("det_bit", det_bit_o, in_bit ? bits_q[0].b : IB);
      chk("result_valid", ifc.result_valid_o, m_slot_full);
      nfull = m_slot_full && !ifc.result_ready_i;
      if (in_bit) begin
        e = bits_q.pop_front();
        if (det_hit_i) begin
          if (m_cnt == CntMax) m_sat = 1'b1;
          else m_cnt++;
        end
        if (e.last) begin
          r.cnt = m_cnt; r.sat = m_sat;
          if (slot_ok) begin
            nfull = 1'b1;
            exp_q.push_back(r);
          end else begin
            m_stalled = 1'b1;
            m_pend = r;
          end
        end
      end else if (m_stalled && ifc.result_ready_i) begin
        m_stalled = 1'b0;
        nfull = 1'b1;
        exp_q.push_back(m_pend);
      end
      if (ifc.word_valid_i && exp_ready) begin
        for (int i = WW - 1; i >= 0; i--) begin
          e.b = ifc.word_i[i];
          e.last = (i == 0);
          bits_q.push_back(e);
        end
        m_cnt = 0; m_sat = 1'b0;
      end
      m_slot_full = nfull;
    end
  end

  // Monitor: compares each consumed result against the scoreboard.
  always @(negedge clock_i) begin : monitor
    res_t            r;
    logic            hold;
    logic [CW-1:0]   h_res;
    logic            h_sat;
    if (areset_i) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("result_stable", ifc.result_o, h_res);
        chk("sat_stable", ifc.result_sat_o, h_sat);
      end
      if (ifc.result_valid_o && ifc.result_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL result_unexpected: got %0d expected none", ifc.result_o);
        end else begin
          r = exp_q.pop_front();
          if (ifc.result_o != r.cnt[CW-1:0] || ifc.result_sat_o != r.sat) begin
            bad++;
            $display("FAIL result: got %0d/sat%0d expected %0d/sat%0d", ifc.result_o,
                     ifc.result_sat_o, r.cnt, r.sat);
          end
        end
      end
      hold  = ifc.result_valid_o && !ifc.result_ready_i;
      h_res = ifc.result_o;
      h_sat = ifc.result_sat_o;
    end
  end

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  // Offer a word until taken, then drive hits on the bit indices set in mask.
  task automatic send_word(input logic [WW-1:0] w, input logic [WW-1:0] mask);
    logic acc;
    int   n;
    ifc.word_valid_i = 1'b1;
    ifc.word_i = w;
    det_hit_i = 1'b0;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      #1 acc = ifc.word_ready_o;
      @(posedge clock_i);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got 0 expected 1");
    end
    ifc.word_valid_i = 1'b0;
    for (int k = 0; k < int'(WW); k++) begin
      det_hit_i = mask[k];
      cyc();
    end
    det_hit_i = 1'b0;
  endtask

  initial begin
    int n;
    areset_i = 1'b1;
    ifc.word_valid_i = 1'b0;
    ifc.word_i = '0;
    ifc.result_ready_i = 1'b1;
    det_hit_i = 1'b0;
    repeat (3) cyc();
    areset_i = 1'b0;
    cyc();

    // Hits while idle must not count.
    det_hit_i = 1'b1;
    repeat (10) cyc();
    send_word(8'h40, 8'h08);
    repeat (3) cyc();

    // Single word, hits on bits 2 and 5.
    send_word(8'hB4, 8'h24);
    repeat (3) cyc();

    // Back-to-back streaming.
    ifc.word_valid_i = 1'b1;
    ifc.word_i = 8'hFF;
    det_hit_i = 1'($urandom_range(0, 1));
    cyc();
    ifc.word_i = 8'h00;
    for (int k = 0; k < 8; k++) begin
      det_hit_i = 1'($urandom_range(0, 1));
      cyc();
    end
    ifc.word_valid_i = 1'b0;
    repeat (10) cyc();

    // Backpressure into stall, then release.
    ifc.result_ready_i = 1'b0;
    send_word(8'hA5, 8'h13);
    send_word(8'h3C, 8'h01);
    repeat (4) cyc();
    ifc.result_ready_i = 1'b1;
    repeat (4) cyc();

    // Saturation, then a clean zero-hit word.
    send_word(8'h5A, 8'hFF);
    send_word(8'h00, 8'h00);
    repeat (3) cyc();

    // Reset in the middle of a word.
    ifc.result_ready_i = 1'b0;
    send_word(8'h11, 8'h01);
    ifc.word_valid_i = 1'b1;
    ifc.word_i = 8'hC3;
    cyc();
    ifc.word_valid_i = 1'b0;
    repeat (3) cyc();
    areset_i = 1'b1;
    repeat (3) cyc();
    areset_i = 1'b0;
    ifc.result_ready_i = 1'b1;
    repeat (2) cyc();

    // Randomised traffic with random backpressure and hits.
    for (int c = 0; c < 4000; c++) begin
      ifc.word_valid_i   = ($urandom_range(0, 3) != 0);
      ifc.word_i         = WW'($urandom);
      ifc.result_ready_i = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
      det_hit_i          = 1'($urandom_range(0, 1));
      cyc();
    end

    // Drain outstanding results.
    ifc.word_valid_i = 1'b0;
    ifc.result_ready_i = 1'b1;
    det_hit_i = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || ifc.result_valid_o || busy_o) && n < 100) begin
      cyc();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
